hw_gcd_gcd_req_packer: RTL and testbench

Upstream front-end for the GCD unit. Accepts a single stream of 16-bit operands, pairs consecutive operands (first = a, second = b) into 32-bit `{a,b}` request messages, and buffers them in a small FIFO. Its output stream drives the GCD unit's 32-bit input stream directly. This lets producers that emit one operand per transaction feed the GCD unit without packing logic of their own.

---
 rtl/hw_gcd_gcd_req_packer_pkg.sv | 31 +++
 rtl/hw_gcd_gcd_req_packer_if.sv | 11 +
 rtl/hw_gcd_gcd_req_packer_fifo.sv | 54 +++++
 rtl/hw_gcd_gcd_req_packer.sv | 83 ++++++++
 tb/tb_hw_gcd_gcd_req_packer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hw_gcd_gcd_req_packer_pkg.sv
// Shared GCD types: operand and packed {a,b} request payload.
package hw_gcd_GcdPkg;

    localparam int unsigned OPERAND_W = 16;

    typedef logic [OPERAND_W-1:0] gcd_operand_t;

    typedef struct packed {
        gcd_operand_t a;
        gcd_operand_t b;
    } gcd_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;

    // Larger operand first so the GCD unit skips its initial swap.
    function automatic gcd_req_t sort_req(input gcd_operand_t a, input gcd_operand_t b);
        gcd_req_t r;
        if (a < b) begin
            r.a = b;
            r.b = a;
        end else begin
            r.a = a;
            r.b = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/hw_gcd_gcd_req_packer_if.sv
// Valid/ready stream interface with a parameterised message type.
interface StreamIntf #(
    parameter type t_msg = logic [15:0]
) ();
    t_msg msg;
    logic val;
    logic rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/hw_gcd_gcd_req_packer_fifo.sv
// Power-of-two circular request buffer; data storage is not reset.
module hw_gcd_ReqFifo #(
    parameter type         t_entry = logic [31:0],
    parameter int unsigned p_depth = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_en,
    input  t_entry push_data,
    input  logic   pop_en,
    output t_entry head,
    output logic   full,
    output logic   empty
);
    localparam int unsigned PTR_W = $clog2(p_depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    t_entry           mem [p_depth];

    logic do_push;
    logic do_pop;

    assign do_push = push_en && !full;
    assign do_pop  = pop_en && !empty;

    // Pointers wrap naturally because p_depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(p_depth));
    assign empty = (count == '0);

endmodule

// File: rtl/hw_gcd_gcd_req_packer.sv
// Pairs consecutive 16-bit operands into {a,b} GCD requests and buffers them.
// Optional build macro GCD_PACK_SORT_EN emits {max,min} instead of arrival order.
module hw_gcd_gcd_req_packer
    import hw_gcd_GcdPkg::*;
#(
    parameter int unsigned p_depth = 2
) (
    input  logic      clk,
    input  logic      rst,
    StreamIntf.slave  istream,
    StreamIntf.master ostream
);
    pack_state_t  state;
    pack_state_t  next_state;
    gcd_operand_t a_reg;
    gcd_req_t     push_data;
    gcd_req_t     head;
    logic         push_en;
    logic         pop_en;
    logic         fifo_full;
    logic         fifo_empty;
    logic         in_xfer;

    // Ready depends on registered state only, never on ostream.rdy.
    assign istream.rdy = (state == ST_IDLE) || !fifo_full;
    assign in_xfer     = istream.val && istream.rdy;

    assign ostream.val = !fifo_empty && !rst;
    assign ostream.msg = head;
    assign pop_en      = ostream.val && ostream.rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_xfer) a_reg <= istream.msg;
    end

    always_comb begin
        next_state = state;
        push_en    = 1'b0;
        case (state)
            ST_IDLE: if (in_xfer) next_state = ST_HOLD;
            ST_HOLD: if (in_xfer) begin
                push_en    = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef GCD_PACK_SORT_EN
    assign push_data = sort_req(a_reg, istream.msg);
`else
    assign push_data = '{a: a_reg, b: istream.msg};
`endif

    hw_gcd_ReqFifo #(
        .t_entry (gcd_req_t),
        .p_depth (p_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en),
        .push_data (push_data),
        .pop_en    (pop_en),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fixed-width line: held operand | occupancy | transferred request.
    function automatic string trace();
        string held;
        string outs;
        held = (state == ST_HOLD) ? $sformatf("%04h", a_reg) : "    ";
        outs = (ostream.val && ostream.rdy) ? $sformatf("%08h", ostream.msg) : "        ";
        return $sformatf("%s|%2d|%s", held, u_fifo.count, outs);
    endfunction

endmodule

// File: tb/tb_hw_gcd_gcd_req_packer.sv
// Scoreboard bench for hw_gcd_gcd_req_packer (p_depth = 2).
module tb_hw_gcd_gcd_req_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    StreamIntf #(.t_msg(logic [15:0])) istream ();
    StreamIntf #(.t_msg(logic [31:0])) ostream ();

    hw_gcd_gcd_req_packer #(.p_depth(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .istream (istream),
        .ostream (ostream)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        rand_rdy  = 1'b0;
    logic        rdy_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_req(input logic [15:0] a, input logic [15:0] b);
`ifdef GCD_PACK_SORT_EN
        if (a < b) return {b, a};
`endif
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold until it transfers (bounded).
    task automatic send_op(input logic [15:0] x);
        int cnt;
        istream.msg = x;
        istream.val = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!istream.rdy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!istream.rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: operand %h never accepted", x);
            istream.val = 1'b0;
        end
        tick();
    endtask

    task automatic idle(input int n);
        istream.val = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 300) begin
            tick();
            cnt++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        tick();
    endtask

    // Sole driver of ostream.rdy.
    initial begin
        ostream.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ostream.rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    // Monitor: a transfer at the next edge is decided by val/rdy at negedge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ostream.val && ostream.rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none", ostream.msg);
                end else begin
                    e = exp_q.pop_front();
                    check("ostream_msg", ostream.msg, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [15:0] s_ops [10] = '{16'd3, 16'd9, 16'd27, 16'd15, 16'd21, 16'd49, 16'd40, 16'd40, 16'd0, 16'd12};
`ifdef GCD_PACK_SORT_EN
    logic [31:0] s_exp [5] = '{32'h0009_0003, 32'h001B_000F, 32'h0031_0015, 32'h0028_0028, 32'h000C_0000};
    logic [31:0] b_exp [3] = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005};
`else
    logic [31:0] s_exp [5] = '{32'h0003_0009, 32'h001B_000F, 32'h0015_0031, 32'h0028_0028, 32'h0000_000C};
    logic [31:0] b_exp [3] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006};
`endif
    logic [15:0] b_ops [6] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};

    initial begin
        int          accepted;
        int          idx;
        logic [15:0] ra;
        logic [15:0] rb;

        rst         = 1'b1;
        istream.val = 1'b0;
        istream.msg = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_oval", 32'(ostream.val), 32'd0);
        check("reset_irdy", 32'(istream.rdy), 32'd1);

        // Basic pairing and minimum latency
        exp_q.push_back(32'h000F_0005);
        send_op(16'd15);
        check("lat_val_after_a", 32'(ostream.val), 32'd0);
        send_op(16'd5);
        check("lat_val_after_b", 32'(ostream.val), 32'd1);
        istream.val = 1'b0;
        wait_drain();

        // Back-to-back stream, including a zero operand
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1) exp_q.push_back(s_exp[i/2]);
            send_op(s_ops[i]);
        end
        istream.val = 1'b0;
        wait_drain();

        // Backpressure: 2*p_depth+1 operands accepted before rdy drops
        rdy_fixed = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(b_exp[i]);
        accepted = 0;
        idx = 0;
        istream.val = 1'b1;
        while (idx < 6) begin
            istream.msg = b_ops[idx];
            @(negedge clk);
            if (!istream.rdy) break;
            tick();
            accepted++;
            idx++;
        end
        check("bp_accept_cnt", 32'(accepted), 32'd5);
        repeat (3) tick();
        check("bp_irdy_low", 32'(istream.rdy), 32'd0);
        check("bp_oval_high", 32'(ostream.val), 32'd1);
        rdy_fixed = 1'b1;
        while (idx < 6) begin
            send_op(b_ops[idx]);
            idx++;
        end
        istream.val = 1'b0;
        wait_drain();

        // Reset with a buffered pair and a held operand: only {4,2} survives
        rdy_fixed = 1'b0;
        repeat (2) tick();
        send_op(16'd7);
        send_op(16'd8);
        send_op(16'd7);
        idle(1);
        rst = 1'b1;
        #1;
        check("rst_oval_forced", 32'(ostream.val), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_oval", 32'(ostream.val), 32'd0);
        check("rst_mid_irdy", 32'(istream.rdy), 32'd1);
        rdy_fixed = 1'b1;
        repeat (2) tick();
        exp_q.push_back(exp_req(16'd4, 16'd2));
        send_op(16'd4);
        send_op(16'd2);
        istream.val = 1'b0;
        wait_drain();

        // Random delays on both streams
        rand_rdy = 1'b1;
        for (int p = 0; p < 20; p++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp_q.push_back(exp_req(ra, rb));
            idle($urandom_range(0, 3));
            send_op(ra);
            idle($urandom_range(0, 3));
            send_op(rb);
        end
        istream.val = 1'b0;
        wait_drain();
        rand_rdy = 1'b0;
        repeat (3) tick();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
